// File: rtl/sram_block_copier.sv
// Word-by-word SRAM block copier: reads one 32-bit word, writes it to the
// destination, and repeats. Only one bus transaction is ever in flight.
module sram_block_copier #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [LEN_W-1:0] words_done,
  output logic             m_req_valid,
  input  logic             m_req_ready,
  output logic             m_req_write,
  output logic [31:0]      m_req_addr,
  output logic [31:0]      m_req_wdata,
  output logic [3:0]       m_req_wstrb,
  input  logic             m_rsp_valid,
  input  logic [31:0]      m_rsp_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_ptr, dst_ptr, hold_q;
  logic [LEN_W-1:0] len_q, words_q;
  logic             err_q, aborted_q, abort_pend_q;

  logic load, set_err, set_abort, set_pend, capture, wr_fire;
  logic misaligned, last_word, stop_req;

  assign misaligned = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  // words_q < len_q whenever a write is in flight, so the increment cannot wrap.
  assign last_word  = (words_q + LEN_W'(1)) == len_q;
  assign stop_req   = abort || abort_pend_q;

  // NOTE: every combinational output gets a default before the case so that no
  // path through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    set_err   = 1'b0;
    set_abort = 1'b0;
    set_pend  = 1'b0;
    capture   = 1'b0;
    wr_fire   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (misaligned) begin
            set_err = 1'b1;
            state_d = S_DONE;
          end else if (len_words == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (m_req_ready) begin
          // An abort that coincides with acceptance lets the read finish first.
          set_pend = abort;
          state_d  = S_RD_WAIT;
        end else if (abort) begin
          set_abort = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_RD_WAIT: begin
        capture = m_rsp_valid;
        if (!m_rsp_valid) begin
          set_err   = 1'b1;
          set_abort = stop_req;
          state_d   = S_DONE;
        end else if (stop_req) begin
          set_abort = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (m_req_ready) begin
          wr_fire = 1'b1;
          if (last_word || stop_req) begin
            set_abort = stop_req;
            state_d   = S_DONE;
          end else begin
            state_d = S_RD_REQ;
          end
        end else if (abort) begin
          set_abort = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_ptr      <= '0;
      dst_ptr      <= '0;
      len_q        <= '0;
      words_q      <= '0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      // NOTE: the single-word holding register is small enough to reset, which
      // keeps m_req_wdata deterministic from the first cycle after reset.
      hold_q       <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        src_ptr      <= src_addr;
        dst_ptr      <= dst_addr;
        len_q        <= len_words;
        words_q      <= '0;
        err_q        <= set_err;
        aborted_q    <= 1'b0;
        abort_pend_q <= 1'b0;
      end else begin
        if (set_err)   err_q        <= 1'b1;
        if (set_abort) aborted_q    <= 1'b1;
        if (set_pend)  abort_pend_q <= 1'b1;
        if (wr_fire) begin
          src_ptr <= src_ptr + 32'd4;
          dst_ptr <= dst_ptr + 32'd4;
          words_q <= words_q + LEN_W'(1);
        end
      end
      if (capture) hold_q <= m_rsp_rdata;
    end
  end

  // Bus fields are decoded from registered state only, so they stay stable
  // for as long as a request is stalled.
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err         = err_q;
  assign aborted     = aborted_q;
  assign words_done  = words_q;
  assign m_req_valid = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign m_req_write = (state_q == S_WR_REQ);
  assign m_req_addr  = (state_q == S_RD_REQ) ? src_ptr :
                       (state_q == S_WR_REQ) ? dst_ptr : 32'd0;
  assign m_req_wdata = m_req_write ? hold_q : 32'd0;
  assign m_req_wstrb = m_req_write ? 4'hF : 4'h0;

endmodule

// File: tb/tb_sram_block_copier.sv
// Self-checking bench for sram_block_copier: directed vector table, hand-written
// abort/reset/error sequences and randomized copies against a copy-level model.
module tb_sram_block_copier;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [31:0]      src_addr, dst_addr;
  logic [LEN_W-1:0] len_words;
  logic             busy, done, err, aborted;
  logic [LEN_W-1:0] words_done;
  logic             m_req_valid, m_req_ready, m_req_write;
  logic [31:0]      m_req_addr, m_req_wdata;
  logic [3:0]       m_req_wstrb;
  logic             m_rsp_valid;
  logic [31:0]      m_rsp_rdata;

  always #5 clk = ~clk;

  sram_block_copier #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err), .aborted(aborted),
    .words_done(words_done),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_write(m_req_write), .m_req_addr(m_req_addr),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // SRAM model: sparse storage, unwritten words return an address hash.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ((a ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'd7;
  endfunction

  logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
  int valid_cycles = 0;
  int ready_mode   = 0;  // 0: always ready, 1: stall stall_n cycles, 2: random
  int stall_n      = 0;
  int stall_cnt    = 0;
  bit rsp_pend = 0, suppress_rsp = 0, was_stall = 0, rd_wait_next = 0, prev_abort = 0;
  logic [31:0] rsp_data, prev_addr, prev_wdata;
  logic        prev_write;
  logic [3:0]  prev_wstrb;

  // Interconnect + SRAM responder: drives just after each rising edge,
  // observes the DUT at the falling edge.
  initial begin
    m_req_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      m_rsp_valid = 1'b0;
      m_rsp_rdata = 32'd0;
      if (rsp_pend) begin
        if (suppress_rsp) suppress_rsp = 1'b0;
        else begin
          m_rsp_valid = 1'b1;
          m_rsp_rdata = rsp_data;
        end
        rsp_pend = 1'b0;
      end
      case (ready_mode)
        0:       m_req_ready = 1'b1;
        1:       m_req_ready = (stall_cnt >= stall_n);
        default: m_req_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (rst) begin
        rsp_pend = 0; was_stall = 0; rd_wait_next = 0; stall_cnt = 0;
      end else begin
        if (was_stall && !prev_abort) check("hold_valid", {31'd0, m_req_valid}, 32'd1);
        if (was_stall && m_req_valid) begin
          check("hold_addr",  m_req_addr,  prev_addr);
          check("hold_write", {31'd0, m_req_write}, {31'd0, prev_write});
          check("hold_wdata", m_req_wdata, prev_wdata);
          check("hold_wstrb", {28'd0, m_req_wstrb}, {28'd0, prev_wstrb});
        end
        if (!m_req_valid || !m_req_write) begin
          check("quiet_wstrb", {28'd0, m_req_wstrb}, 32'd0);
          check("quiet_wdata", m_req_wdata, 32'd0);
        end
        if (rd_wait_next) check("one_outstanding", {31'd0, m_req_valid}, 32'd0);
        rd_wait_next = 1'b0;
        if (m_req_valid) valid_cycles++;
        if (m_req_valid && m_req_ready) begin
          stall_cnt = 0;
          if (m_req_write) begin
            wr_addr_log.push_back(m_req_addr);
            wr_data_log.push_back(m_req_wdata);
            mem[m_req_addr] = m_req_wdata;
          end else begin
            rd_log.push_back(m_req_addr);
            rsp_pend     = 1'b1;
            rsp_data     = mem_rd(m_req_addr);
            rd_wait_next = 1'b1;
          end
        end else if (m_req_valid) stall_cnt++;
        else stall_cnt = 0;
        was_stall  = m_req_valid && !m_req_ready;
        prev_abort = abort;
        prev_addr  = m_req_addr;
        prev_write = m_req_write;
        prev_wdata = m_req_wdata;
        prev_wstrb = m_req_wstrb;
      end
    end
  end

  // Copy-level reference: a misaligned copy moves nothing, otherwise word i
  // moves from src+4i to dst+4i (32-bit wrap), earlier words visible to later reads.
  function automatic void model_copy(input logic [31:0] s, input logic [31:0] d,
                                     input logic [LEN_W-1:0] l);
    logic [31:0] sa, da, v;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) return;
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 32'(i) * 32'd4;
      da = d + 32'(i) * 32'd4;
      v  = mem_rd(sa);
      for (int j = 0; j < exp_wa.size(); j++) if (exp_wa[j] == sa) v = exp_wd[j];
      exp_rd.push_back(sa);
      exp_wa.push_back(da);
      exp_wd.push_back(v);
    end
  endfunction

  task automatic compare_traffic(input string tag);
    check({tag, "_rd_count"}, 32'(rd_log.size()), 32'(exp_rd.size()));
    check({tag, "_wr_count"}, 32'(wr_addr_log.size()), 32'(exp_wa.size()));
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      check({tag, "_rd_addr"}, rd_log[i], exp_rd[i]);
    for (int i = 0; i < wr_addr_log.size() && i < exp_wa.size(); i++) begin
      check({tag, "_wr_addr"}, wr_addr_log[i], exp_wa[i]);
      check({tag, "_wr_data"}, wr_data_log[i], exp_wd[i]);
    end
  endtask

  // poke_kind 1: stray start at loop cycle poke_cyc; 2: one-cycle abort there.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input logic [LEN_W-1:0] l, input int poke_cyc, input int poke_kind,
                          output int busy_cyc, output int done_cnt,
                          output logic e, output logic a, output logic [LEN_W-1:0] wd);
    bit seen;
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    valid_cycles = 0;
    busy_cyc = 0; done_cnt = 0; e = 1'b0; a = 1'b0; wd = '0; seen = 1'b0;
    src_addr = s; dst_addr = d; len_words = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (c == poke_cyc && poke_kind == 1) begin
        start = 1'b1; src_addr = s + 32'h100; dst_addr = d + 32'h400; len_words = l + 1'b1;
      end
      if (c == poke_cyc && poke_kind == 2) abort = 1'b1;
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++; seen = 1'b1; e = err; a = aborted; wd = words_done;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (done) done_cnt++;
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    string            name;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    int               stall;
    logic             exp_err;
    logic [LEN_W-1:0] exp_words;
    int               exp_busy;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int bc, dc;
    logic e, a;
    logic [LEN_W-1:0] wd;
    logic [31:0] s, d;
    logic [LEN_W-1:0] l;

    vecs[0] = '{"basic",     32'h0001_0000, 32'h0002_0000, 16'd4, 0, 1'b0, 16'd4, 13};
    vecs[1] = '{"backpress", 32'h0001_0100, 32'h0002_0100, 16'd2, 3, 1'b0, 16'd2, 19};
    vecs[2] = '{"len0",      32'h0001_0000, 32'h0002_0000, 16'd0, 0, 1'b0, 16'd0, 1};
    vecs[3] = '{"src_mis",   32'h0001_0002, 32'h0002_0000, 16'd4, 0, 1'b1, 16'd0, 1};
    vecs[4] = '{"dst_mis",   32'h0001_0000, 32'h0002_0001, 16'd4, 0, 1'b1, 16'd0, 1};
    vecs[5] = '{"wrap",      32'hFFFF_FFFC, 32'h0003_0000, 16'd2, 0, 1'b0, 16'd2, 7};
    vecs[6] = '{"len1",      32'h0001_0200, 32'h0002_0200, 16'd1, 0, 1'b0, 16'd1, 4};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len_words = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_err",   {31'd0, err},   32'd0);
    check("rst_abort", {31'd0, aborted}, 32'd0);
    check("rst_words", 32'(words_done), 32'd0);
    check("rst_valid", {31'd0, m_req_valid}, 32'd0);
    check("rst_addr",  m_req_addr, 32'd0);
    check("rst_wstrb", {28'd0, m_req_wstrb}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      ready_mode = (vecs[i].stall != 0) ? 1 : 0;
      stall_n    = vecs[i].stall;
      model_copy(vecs[i].src, vecs[i].dst, vecs[i].len);
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, -1, 0, bc, dc, e, a, wd);
      check({vecs[i].name, "_err"},   {31'd0, e}, {31'd0, vecs[i].exp_err});
      check({vecs[i].name, "_abort"}, {31'd0, a}, 32'd0);
      check({vecs[i].name, "_words"}, 32'(wd), 32'(vecs[i].exp_words));
      check({vecs[i].name, "_busy"},  32'(bc), 32'(vecs[i].exp_busy));
      check({vecs[i].name, "_done1"}, 32'(dc), 32'd1);
      compare_traffic(vecs[i].name);
      if (vecs[i].exp_words == '0) check({vecs[i].name, "_no_valid"}, 32'(valid_cycles), 32'd0);
    end

    // Abort while idle does nothing.
    @(posedge clk); #1;
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_abort_busy",    {31'd0, busy},    32'd0);
    check("idle_abort_aborted", {31'd0, aborted}, 32'd0);
    abort = 1'b0;

    // A start pulse during a copy is ignored.
    ready_mode = 0;
    model_copy(32'h0001_0300, 32'h0002_0300, 16'd3);
    run_copy(32'h0001_0300, 32'h0002_0300, 16'd3, 2, 1, bc, dc, e, a, wd);
    check("busy_start_words", 32'(wd), 32'd3);
    check("busy_start_busy",  32'(bc), 32'd10);
    compare_traffic("busy_start");

    // Abort in RD_WAIT of word 2: word 2 is read but never written.
    model_copy(32'h0001_0400, 32'h0002_0400, 16'd1);
    exp_rd.push_back(32'h0001_0404);
    run_copy(32'h0001_0400, 32'h0002_0400, 16'd5, 4, 2, bc, dc, e, a, wd);
    check("abort_rw_words",   32'(wd), 32'd1);
    check("abort_rw_aborted", {31'd0, a}, 32'd1);
    check("abort_rw_err",     {31'd0, e}, 32'd0);
    check("abort_rw_busy",    32'(bc), 32'd6);
    compare_traffic("abort_rw");

    // Abort on a stalled, unaccepted first read.
    ready_mode = 1; stall_n = 3;
    model_copy(32'h0001_0500, 32'h0002_0500, 16'd0);
    run_copy(32'h0001_0500, 32'h0002_0500, 16'd3, 0, 2, bc, dc, e, a, wd);
    check("abort_rq_words",   32'(wd), 32'd0);
    check("abort_rq_aborted", {31'd0, a}, 32'd1);
    check("abort_rq_busy",    32'(bc), 32'd2);
    compare_traffic("abort_rq");

    // Missing read response.
    ready_mode = 0;
    suppress_rsp = 1'b1;
    model_copy(32'h0001_0600, 32'h0002_0600, 16'd0);
    exp_rd.push_back(32'h0001_0600);
    run_copy(32'h0001_0600, 32'h0002_0600, 16'd3, -1, 0, bc, dc, e, a, wd);
    check("norsp_err",   {31'd0, e}, 32'd1);
    check("norsp_words", 32'(wd), 32'd0);
    check("norsp_busy",  32'(bc), 32'd3);
    check("norsp_done1", 32'(dc), 32'd1);
    compare_traffic("norsp");
    repeat (2) @(posedge clk);
    #1;
    check("norsp_err_held", {31'd0, err}, 32'd1);

    // Reset during WR_REQ of word 2.
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    src_addr = 32'h0001_0700; dst_addr = 32'h0002_0700; len_words = 16'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_write", {31'd0, m_req_write}, 32'd1);
    check("pre_rst_words", 32'(words_done), 32'd1);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy",  {31'd0, busy},  32'd0);
    check("mid_rst_done",  {31'd0, done},  32'd0);
    check("mid_rst_words", 32'(words_done), 32'd0);
    check("mid_rst_valid", {31'd0, m_req_valid}, 32'd0);
    check("mid_rst_write", {31'd0, m_req_write}, 32'd0);
    check("mid_rst_addr",  m_req_addr,  32'd0);
    check("mid_rst_wdata", m_req_wdata, 32'd0);
    check("mid_rst_wstrb", {28'd0, m_req_wstrb}, 32'd0);
    check("mid_rst_err",   {31'd0, err}, 32'd0);
    check("mid_rst_abort", {31'd0, aborted}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    check("rst_start_ignored", {31'd0, busy}, 32'd0);
    check("rst_wr_count", 32'(wr_addr_log.size()), 32'd1);

    // Randomized copies with random backpressure.
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      s = 32'h1000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      d = 32'h2000_0000 + 32'($urandom_range(0, 255)) * 32'd4;
      l = LEN_W'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) s = s + 32'($urandom_range(1, 3));
      model_copy(s, d, l);
      run_copy(s, d, l, -1, 0, bc, dc, e, a, wd);
      check("rnd_err",   {31'd0, e}, {31'd0, (s[1:0] != 2'b00)});
      check("rnd_words", 32'(wd), 32'(exp_wa.size()));
      check("rnd_abort", {31'd0, a}, 32'd0);
      check("rnd_done1", 32'(dc), 32'd1);
      compare_traffic("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
